// File: rtl/dmem_responder.sv
// Data-memory bus responder: word RAM, MMIO window (console TX FIFO,
// status, cycle counter, FIFO occupancy) behind one synchronous read port.
module dmem_responder #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                RAM_DEPTH  = 256,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hFF0,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              bus_err
);

  localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [ADDR_W-1:0] RAM_END = ADDR_W'(RAM_DEPTH);
  localparam logic [CW-1:0]     FULL_C  = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] ram_q  [RAM_DEPTH];
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] cyc_q, cyc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic              berr_q, berr_d;

  logic              is_ram, is_mmio, is_unm;
  logic [ADDR_W-1:0] off;
  logic [RAW-1:0]    ram_idx;
  logic              full, empty;
  logic              wr_tx, wr_stat, wr_cyc;
  logic              push, pop, drop;

  assign is_ram  = address_dmem < RAM_END;
  assign is_mmio = address_dmem >= MMIO_BASE;
  assign is_unm  = !is_ram && !is_mmio;
  assign off     = address_dmem - MMIO_BASE;
  assign ram_idx = address_dmem[RAW-1:0];

  assign full  = cnt_q == FULL_C;
  assign empty = cnt_q == '0;

  assign wr_tx   = wren && is_mmio && off == ADDR_W'(0);
  assign wr_stat = wren && is_mmio && off == ADDR_W'(1);
  assign wr_cyc  = wren && is_mmio && off == ADDR_W'(2);

  // A pop frees the slot a same-edge push needs, so full+pop never drops.
  assign pop  = !empty && out_ready;
  assign push = wr_tx && (!full || pop);
  assign drop = wr_tx && full && !pop;

  always_comb begin
    q_d = '0;
    unique case (1'b1)
      is_ram: q_d = ram_q[ram_idx];
      is_mmio: begin
        unique case (off)
          ADDR_W'(1): q_d = {{(DATA_W-4){1'b0}},
                             berr_q, ovf_q, full, empty};
          ADDR_W'(2): q_d = cyc_q;
          ADDR_W'(3): q_d = DATA_W'(cnt_q);
          default:    q_d = '0;
        endcase
      end
      default: q_d = '0;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d  = (ovf_q && !(wr_stat && data[2])) || drop;
    berr_d = (berr_q && !(wr_stat && data[3])) || is_unm;
    cyc_d  = wr_cyc ? data : cyc_q + DATA_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      cyc_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cyc_q  <= cyc_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      berr_q <= berr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wren && is_ram) ram_q[ram_idx] <= data;
    if (push)           fifo_q[wr_q]   <= data;
  end

  assign q_dmem    = q_q;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : fifo_q[rd_q];
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan steps plus random traffic
// compared against a queue/array reference model.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_ram [int];
  logic [31:0] m_fifo [$];
  logic [31:0] m_cyc = '0;
  bit          m_ov = 0;
  bit          m_be = 0;

  localparam logic [11:0] IDLE = 12'd5;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_cyc = '0;
    m_ov  = 0;
    m_be  = 0;
  endtask

  task automatic step(input logic [11:0] a, input logic [31:0] d,
                      input logic w, input logic r);
    logic [31:0] exp_q;
    bit full, empty, pop, unm;
    int off;
    address_dmem = a;
    data         = d;
    wren         = w;
    out_ready    = r;
    full  = m_fifo.size() == 8;
    empty = m_fifo.size() == 0;
    pop   = !empty && r;
    unm   = a >= 12'd256 && a < 12'hFF0;
    off   = int'(a) - 'hFF0;
    exp_q = '0;
    if (a < 12'd256) exp_q = m_ram[int'(a)];
    else if (!unm) begin
      case (off)
        1: exp_q = {28'b0, m_be, m_ov, full, empty};
        2: exp_q = m_cyc;
        3: exp_q = 32'(m_fifo.size());
        default: exp_q = '0;
      endcase
    end
    if (w && a == 12'hFF1) begin
      if (d[2]) m_ov = 0;
      if (d[3]) m_be = 0;
    end
    if (unm) m_be = 1;
    if (pop) void'(m_fifo.pop_front());
    if (w && a == 12'hFF0) begin
      if (!full || pop) m_fifo.push_back(d);
      else m_ov = 1;
    end
    m_cyc = (w && a == 12'hFF2) ? d : m_cyc + 32'd1;
    if (w && a < 12'd256) m_ram[int'(a)] = d;
    @(posedge clock);
    #1;
    check("q_dmem", q_dmem, exp_q);
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    check("out_data", out_data, m_fifo.size() != 0 ? m_fifo[0] : 32'd0);
    check("bus_err", 32'(bus_err), 32'(m_be));
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_q", q_dmem, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_berr", 32'(bus_err), 32'd0);
    #9 reset = 1'b1;
    model_reset();

    // 1: RAM read-before-write
    step(12'd5, 32'hDEADBEEF, 1, 0);
    step(12'd5, 32'd0, 0, 0);
    check("t1_rd", q_dmem, 32'hDEADBEEF);
    step(12'd5, 32'd1, 1, 0);
    check("t1_rbw", q_dmem, 32'hDEADBEEF);
    step(12'd5, 32'd0, 0, 0);
    check("t1_new", q_dmem, 32'd1);

    // 2: fill, overflow, drain
    for (int i = 1; i <= 9; i++) step(12'hFF0, 32'(i), 1, 0);
    step(12'hFF3, 32'd0, 0, 0);
    check("t2_cnt", q_dmem, 32'd8);
    step(12'hFF1, 32'd0, 0, 0);
    check("t2_stat", q_dmem, 32'h6);
    for (int i = 1; i <= 8; i++) begin
      check("t2_head", out_data, 32'(i));
      step(IDLE, 32'd0, 0, 1);
    end
    check("t2_empty", 32'(out_valid), 32'd0);
    step(12'hFF1, 32'd0, 0, 0);
    check("t2_stat2", q_dmem, 32'h5);
    step(12'hFF1, 32'h4, 1, 0);

    // 3: push and pop together while full
    for (int i = 0; i < 8; i++) step(12'hFF0, 32'h10 + 32'(i), 1, 0);
    check("t3_head0", out_data, 32'h10);
    step(12'hFF0, 32'hA5, 1, 1);
    step(12'hFF3, 32'd0, 0, 0);
    check("t3_cnt", q_dmem, 32'd8);
    step(12'hFF1, 32'd0, 0, 0);
    check("t3_stat", q_dmem, 32'h2);
    for (int i = 1; i < 8; i++) begin
      check("t3_head", out_data, 32'h10 + 32'(i));
      step(IDLE, 32'd0, 0, 1);
    end
    check("t3_a5", out_data, 32'hA5);
    step(IDLE, 32'd0, 0, 1);
    check("t3_empty", 32'(out_valid), 32'd0);

    // 4: unmapped access, W1C clear
    step(12'h400, 32'd0, 0, 0);
    check("t4_q", q_dmem, 32'd0);
    check("t4_berr", 32'(bus_err), 32'd1);
    step(12'hFF1, 32'h8, 1, 0);
    check("t4_clr", 32'(bus_err), 32'd0);
    step(12'hFF1, 32'd0, 0, 0);
    check("t4_bit3", q_dmem & 32'h8, 32'd0);

    // 5: cycle counter load and wrap
    step(12'hFF2, 32'hFFFFFFFE, 1, 0);
    step(12'hFF2, 32'd0, 0, 0);
    check("t5_c0", q_dmem, 32'hFFFFFFFE);
    step(12'hFF2, 32'd0, 0, 0);
    check("t5_c1", q_dmem, 32'hFFFFFFFF);
    step(12'hFF2, 32'd0, 0, 0);
    check("t5_c2", q_dmem, 32'h0);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(12'hFF0, 32'h30 + 32'(i), 1, 0);
    step(12'h400, 32'd0, 0, 0);
    step(IDLE, 32'd0, 0, 0);
    check("t6_pre", q_dmem, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_q", q_dmem, 32'd0);
    check("t6_berr", 32'(bus_err), 32'd0);
    #2 reset = 1'b1;
    model_reset();
    step(12'hFF2, 32'd0, 0, 0);
    check("t6_cyc", q_dmem, 32'd0);
    step(12'hFF3, 32'd0, 0, 0);
    check("t6_cnt", q_dmem, 32'd0);

    // random traffic
    for (int i = 0; i < 16; i++) step(12'(i), $urandom, 1, 0);
    for (int n = 0; n < 600; n++) begin
      logic [11:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)      a = 12'($urandom_range(0, 15));
      else if (sel <= 6) a = 12'hFF0;
      else if (sel == 7) a = 12'($urandom_range('hFF1, 'hFF3));
      else if (sel == 8) a = 12'($urandom_range('hFF4, 'hFFF));
      else               a = 12'($urandom_range(256, 'hFEF));
      step(a, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
